control_sequencer: RTL

Hardwired Moore control unit for the 32-bit bus-based datapath. It steps through fetch (T0–T2) and per-opcode execute states (T3–T7), and drives the one-hot datapath strobes from the current state. Those strobes are PCout, MARin, IncPC, Zin, Zlowout, Gra/Grb/Grc, Rin/Rout, BAout, Cout and the ALU selects. It sits upstream of the datapath and replaces hand-driven testbench sequencing. Memory states stall on a ready handshake.

---
 rtl/cpu_defs_pkg.sv | 66 ++++++
 rtl/op_decoder.sv | 33 +++
 rtl/control_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared opcode, IR field, state and strobe definitions for the hardwired control unit.
// No logic here; consumed by op_decoder and control_sequencer.
package cpu_defs_pkg;

  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;
  localparam int IR_C_MSB  = 18;
  localparam int IR_C_LSB  = 0;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_LD, CL_LDI, CL_ST, CL_ALU_R, CL_ALU_I, CL_NOP, CL_HALT, CL_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic add;
    logic sub;
    logic and_op;
    logic or_op;
  } alu_sel_t;

  typedef struct packed {
    logic     pc_out;
    logic     pc_in;
    logic     inc_pc;
    logic     mar_in;
    logic     mdr_in;
    logic     mdr_out;
    logic     ir_in;
    logic     y_in;
    logic     z_in;
    logic     zlow_out;
    logic     c_out;
    logic     read;
    logic     write;
    logic     gra;
    logic     grb;
    logic     grc;
    logic     r_in;
    logic     r_out;
    logic     ba_out;
    alu_sel_t alu;
  } strobe_t;

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode classifier: instruction class plus one-hot ALU select.
// Zero latency; no flow control.
module op_decoder
  import cpu_defs_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] op,
  output iclass_t        iclass,
  output alu_sel_t       alu_sel
);

  always_comb begin
    iclass  = CL_ILLEGAL;
    alu_sel = '0;
    case (op)
      OP_LD:   begin iclass = CL_LD;    alu_sel.add    = 1'b1; end
      OP_LDI:  begin iclass = CL_LDI;   alu_sel.add    = 1'b1; end
      OP_ST:   begin iclass = CL_ST;    alu_sel.add    = 1'b1; end
      OP_ADD:  begin iclass = CL_ALU_R; alu_sel.add    = 1'b1; end
      OP_SUB:  begin iclass = CL_ALU_R; alu_sel.sub    = 1'b1; end
      OP_AND:  begin iclass = CL_ALU_R; alu_sel.and_op = 1'b1; end
      OP_OR:   begin iclass = CL_ALU_R; alu_sel.or_op  = 1'b1; end
      OP_ADDI: begin iclass = CL_ALU_I; alu_sel.add    = 1'b1; end
      OP_ANDI: begin iclass = CL_ALU_I; alu_sel.and_op = 1'b1; end
      OP_ORI:  begin iclass = CL_ALU_I; alu_sel.or_op  = 1'b1; end
      OP_NOP:  iclass = CL_NOP;
      OP_HALT: iclass = CL_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control FSM: fetch T0-T2, execute T3-T7; strobes decoded from state (and IR class).
// T1, ld T6 and st T7 hold until mem_ready; stop is taken only at the instruction boundary.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        run,
  output logic        illegal
);

  state_t   state;
  state_t   boundary;
  iclass_t  iclass;
  alu_sel_t alu_sel;
  strobe_t  st;
  logic     is_mem_class;
  logic     unused_fields;

  op_decoder #(.OPW(OPW)) u_dec (
    .op      (ir[IR_OP_LSB +: OPW]),
    .iclass  (iclass),
    .alu_sel (alu_sel)
  );

  // Register fields are consumed by the datapath, not the sequencer.
  assign unused_fields = ^{ir[IR_RA_MSB:IR_RA_LSB], ir[IR_RB_MSB:IR_RB_LSB],
                           ir[IR_RC_MSB:IR_RC_LSB], ir[IR_C_MSB:IR_C_LSB]};

  assign boundary     = stop ? HALT : T0;
  assign is_mem_class = (iclass == CL_LD) || (iclass == CL_ST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= T0;
        T0:      state <= T1;
        T1:      if (mem_ready) state <= T2;
        T2: begin
          case (iclass)
            CL_NOP:  state <= boundary;
            CL_HALT: state <= HALT;
            default: state <= T3;
          endcase
        end
        T3:      state <= (iclass == CL_ILLEGAL) ? boundary : T4;
        T4:      state <= T5;
        T5:      state <= is_mem_class ? T6 : boundary;
        T6:      if (iclass != CL_LD || mem_ready) state <= T7;
        T7:      if (iclass != CL_ST || mem_ready) state <= boundary;
        HALT:    state <= HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    st = '0;
    case (state)
      T0: begin st.pc_out = 1'b1; st.mar_in = 1'b1; st.inc_pc = 1'b1; st.z_in = 1'b1; end
      T1: begin st.zlow_out = 1'b1; st.pc_in = 1'b1; st.read = 1'b1; st.mdr_in = 1'b1; end
      T2: begin st.mdr_out = 1'b1; st.ir_in = 1'b1; end
      T3: begin
        if (is_mem_class || iclass == CL_LDI) begin
          st.grb = 1'b1; st.ba_out = 1'b1; st.y_in = 1'b1;
        end else if (iclass == CL_ALU_R || iclass == CL_ALU_I) begin
          st.grb = 1'b1; st.r_out = 1'b1; st.y_in = 1'b1;
        end
      end
      T4: begin
        st.z_in = 1'b1;
        st.alu  = alu_sel;
        if (iclass == CL_ALU_R) begin
          st.grc = 1'b1; st.r_out = 1'b1;
        end else begin
          st.c_out = 1'b1;
        end
      end
      T5: begin
        st.zlow_out = 1'b1;
        if (is_mem_class) st.mar_in = 1'b1;
        else begin st.gra = 1'b1; st.r_in = 1'b1; end
      end
      T6: begin
        st.mdr_in = 1'b1;
        if (iclass == CL_LD) st.read = 1'b1;
        else begin st.gra = 1'b1; st.r_out = 1'b1; end
      end
      T7: begin
        if (iclass == CL_LD) begin
          st.mdr_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1;
        end else begin
          st.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PCout   = st.pc_out;
  assign PCin    = st.pc_in;
  assign IncPC   = st.inc_pc;
  assign MARin   = st.mar_in;
  assign MDRin   = st.mdr_in;
  assign MDRout  = st.mdr_out;
  assign IRin    = st.ir_in;
  assign Yin     = st.y_in;
  assign Zin     = st.z_in;
  assign Zlowout = st.zlow_out;
  assign Cout    = st.c_out;
  assign Read    = st.read;
  assign Write   = st.write;
  assign Gra     = st.gra;
  assign Grb     = st.grb;
  assign Grc     = st.grc;
  assign Rin     = st.r_in;
  assign Rout    = st.r_out;
  assign BAout   = st.ba_out;
  assign ADD     = st.alu.add;
  assign SUB     = st.alu.sub;
  assign AND     = st.alu.and_op;
  assign OR      = st.alu.or_op;
  assign run     = (state != S_RESET) && (state != HALT);
  assign illegal = (state == T3) && (iclass == CL_ILLEGAL);

endmodule
